cmplx_mult_pipe: RTL and testbench

//  Pipelined, parametrised complex multiplier for the sync/receiver datapath.

---
 rtl/cmplx_mult_pipe_pkg.sv | 21 ++
 rtl/cmplx_mult_pipe_round_sat.sv | 51 +++++
 rtl/cmplx_mult_pipe.sv | 152 +++++++++++++++
 tb/tb_cmplx_mult_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cmplx_mult_pipe_pkg.sv
// Shared definitions for the complex multiplier datapath.
//  - ROUND_* / SAT_* encodings for the round_sat stage
//  - default Q-format widths (Q15 inputs, Q15 outputs)
//  - width helper for the full-precision product path
package cmplx_mult_pipe_pkg;

    localparam int ROUND_TRUNC  = 0;
    localparam int ROUND_HALFUP = 1;
    localparam int SAT_WRAP     = 0;
    localparam int SAT_CLAMP    = 1;

    localparam int DEF_IN_W  = 16;
    localparam int DEF_OUT_W = 16;
    localparam int DEF_SHIFT = 15;

    // Product/sum path width: one headroom bit above the exact 2*IN_W+2 result.
    function automatic int full_w(input int in_w);
        return 2 * in_w + 3;
    endfunction

endpackage

// File: rtl/cmplx_mult_pipe_round_sat.sv
// round_sat: combinational scale, round and saturate/wrap of one component.
// Ports:
//  x_in     in   IN_W_FULL  full-precision signed value
//  y_out    out  OUT_W      scaled, rounded and clamped (or wrapped) value
//  ovf_out  out  1          scaled value did not fit in OUT_W (reported for SAT_WRAP too)
module round_sat
    import cmplx_mult_pipe_pkg::*;
#(
    parameter int IN_W_FULL = 35,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int SHIFT     = DEF_SHIFT,
    parameter int ROUND     = ROUND_HALFUP,
    parameter int SAT       = SAT_CLAMP
) (
    input  logic signed [IN_W_FULL-1:0] x_in,
    output logic signed [OUT_W-1:0]     y_out,
    output logic                        ovf_out
);

    // One extra bit so adding the rounding constant can never wrap.
    localparam int EXT_W  = IN_W_FULL + 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    // With SHIFT=0 there is nothing to round away, so the constant is zero.
    localparam logic signed [EXT_W-1:0] RND_C =
        (ROUND == ROUND_HALFUP && SHIFT > 0) ? (EXT_W'(1'b1) << RND_SH) : '0;
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [EXT_W-1:0] rnd_s;
    logic signed [EXT_W-1:0] shf_s;
    logic [EXT_W-OUT_W:0]    hi_s;
    logic                    in_range_s;

    // Round, arithmetic shift, range check and clamp/wrap selection.
    always_comb begin
        rnd_s      = $signed({x_in[IN_W_FULL-1], x_in}) + RND_C;
        shf_s      = rnd_s >>> SHIFT;
        // In range exactly when every bit from the OUT_W sign bit upward agrees.
        hi_s       = shf_s[EXT_W-1:OUT_W-1];
        in_range_s = (&hi_s) | (~|hi_s);
        ovf_out    = ~in_range_s;
        if (in_range_s) begin
            y_out = shf_s[OUT_W-1:0];
        end else if (SAT == SAT_CLAMP) begin
            y_out = shf_s[EXT_W-1] ? OUT_MIN : OUT_MAX;
        end else begin
            y_out = shf_s[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/cmplx_mult_pipe.sv
// cmplx_mult_pipe: pipelined complex multiplier p = a*b or a*conj(b) using
// three real multipliers, scaled by SHIFT, rounded and saturated to OUT_W.
// A sample taken at edge N appears on p_i/p_q with output_strobe after edge N+3.
// Ports:
//  CLK, s_RST            clock (rising) and synchronous active-high reset
//  a_i,a_q,b_i,b_q       signed IN_W operands
//  conj_b                use conj(b); qualified by input_strobe
//  input_strobe          operands valid this cycle
//  ovf_clr               clears the sticky overflow flag (a new overflow wins)
//  p_i,p_q               signed OUT_W result, held while output_strobe=0
//  output_strobe         p_i/p_q valid this cycle
//  ovf                   sticky: a result left the OUT_W range
module cmplx_mult_pipe
    import cmplx_mult_pipe_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int ROUND = ROUND_HALFUP,
    parameter int SAT   = SAT_CLAMP
) (
    input  logic                    CLK,
    input  logic                    s_RST,
    input  logic signed [IN_W-1:0]  a_i,
    input  logic signed [IN_W-1:0]  a_q,
    input  logic signed [IN_W-1:0]  b_i,
    input  logic signed [IN_W-1:0]  b_q,
    input  logic                    conj_b,
    input  logic                    input_strobe,
    input  logic                    ovf_clr,
    output logic signed [OUT_W-1:0] p_i,
    output logic signed [OUT_W-1:0] p_q,
    output logic                    output_strobe,
    output logic                    ovf
);

    localparam int FULL_W = full_w(IN_W);
    localparam int CJ_W   = IN_W + 1;
    localparam int PRE_W  = IN_W + 2;

    if (OUT_W + SHIFT > 2 * IN_W + 2) begin : g_bad_cfg
        $error("cmplx_mult_pipe: OUT_W + SHIFT must not exceed 2*IN_W+2");
    end

    logic signed [CJ_W-1:0]   bq_c_s;
    logic signed [PRE_W-1:0]  s1_c_s, s2_c_s, s3_c_s;
    logic                     v1_r, v2_r, v3_r;
    logic signed [IN_W-1:0]   a_i_r, b_i_r;
    logic signed [CJ_W-1:0]   bq_r;
    logic signed [PRE_W-1:0]  s1_r, s2_r, s3_r;
    logic signed [FULL_W-1:0] m0_r, m1_r, m2_r;
    logic signed [FULL_W-1:0] fi_r, fq_r;
    logic signed [OUT_W-1:0]  y_i_s, y_q_s;
    logic                     ovf_i_s, ovf_q_s;

    // Conjugate (one extra bit so negating the most negative value is exact) and pre-adds.
    always_comb begin
        if (conj_b) begin
            bq_c_s = -CJ_W'(b_q);
        end else begin
            bq_c_s = CJ_W'(b_q);
        end
        s1_c_s = PRE_W'(b_i) + PRE_W'(bq_c_s);
        s2_c_s = PRE_W'(a_i) + PRE_W'(a_q);
        s3_c_s = PRE_W'(a_q) - PRE_W'(a_i);
    end

    // Valid bits: the strobe walks down the pipe; reset drops all in-flight samples.
    always_ff @(posedge CLK) begin
        if (s_RST) begin
            v1_r          <= 1'b0;
            v2_r          <= 1'b0;
            v3_r          <= 1'b0;
            output_strobe <= 1'b0;
        end else begin
            v1_r          <= input_strobe;
            v2_r          <= v1_r;
            v3_r          <= v2_r;
            output_strobe <= v3_r;
        end
    end

    // Datapath stages 1-3; each stage loads only behind a valid sample.
    always_ff @(posedge CLK) begin
        if (s_RST) begin
            a_i_r <= '0;
            b_i_r <= '0;
            bq_r  <= '0;
            s1_r  <= '0;
            s2_r  <= '0;
            s3_r  <= '0;
            m0_r  <= '0;
            m1_r  <= '0;
            m2_r  <= '0;
            fi_r  <= '0;
            fq_r  <= '0;
        end else begin
            if (input_strobe) begin
                a_i_r <= a_i;
                b_i_r <= b_i;
                bq_r  <= bq_c_s;
                s1_r  <= s1_c_s;
                s2_r  <= s2_c_s;
                s3_r  <= s3_c_s;
            end
            if (v1_r) begin
                m0_r <= FULL_W'(a_i_r) * FULL_W'(s1_r);
                m1_r <= FULL_W'(bq_r)  * FULL_W'(s2_r);
                m2_r <= FULL_W'(b_i_r) * FULL_W'(s3_r);
            end
            if (v2_r) begin
                // I = ai*bi - aq*bq', Q = ai*bq' + aq*bi
                fi_r <= m0_r - m1_r;
                fq_r <= m0_r + m2_r;
            end
        end
    end

    round_sat #(
        .IN_W_FULL(FULL_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .ROUND(ROUND), .SAT(SAT)
    ) u_rs_i (
        .x_in(fi_r), .y_out(y_i_s), .ovf_out(ovf_i_s)
    );

    round_sat #(
        .IN_W_FULL(FULL_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .ROUND(ROUND), .SAT(SAT)
    ) u_rs_q (
        .x_in(fq_r), .y_out(y_q_s), .ovf_out(ovf_q_s)
    );

    // Output registers and sticky overflow; a fresh overflow beats ovf_clr.
    always_ff @(posedge CLK) begin
        if (s_RST) begin
            p_i <= '0;
            p_q <= '0;
            ovf <= 1'b0;
        end else begin
            if (v3_r) begin
                p_i <= y_i_s;
                p_q <= y_q_s;
            end
            if (v3_r && (ovf_i_s || ovf_q_s)) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end else begin
                ovf <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_cmplx_mult_pipe.sv
// Directed bench for cmplx_mult_pipe: five instances sharing one stimulus
// (four ROUND/SAT combinations at default widths plus an exact SHIFT=0 build).
module tb_cmplx_mult_pipe;

    logic CLK = 1'b0;
    logic s_RST;
    logic signed [15:0] a_i, a_q, b_i, b_q;
    logic conj_b, input_strobe, ovf_clr;

    // d: ROUND=1 SAT=1, t: ROUND=0 SAT=1, w: ROUND=1 SAT=0, tw: ROUND=0 SAT=0, x: exact
    logic signed [15:0] pi_d, pq_d, pi_t, pq_t, pi_w, pq_w, pi_tw, pq_tw;
    logic signed [33:0] pi_x, pq_x;
    logic os_d, os_t, os_w, os_tw, os_x;
    logic ovf_d, ovf_t, ovf_w, ovf_tw, ovf_x;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    cmplx_mult_pipe #(.IN_W(16), .OUT_W(16), .SHIFT(15), .ROUND(1), .SAT(1)) dut (
        .CLK(CLK), .s_RST(s_RST), .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q),
        .conj_b(conj_b), .input_strobe(input_strobe), .ovf_clr(ovf_clr),
        .p_i(pi_d), .p_q(pq_d), .output_strobe(os_d), .ovf(ovf_d));
    cmplx_mult_pipe #(.IN_W(16), .OUT_W(16), .SHIFT(15), .ROUND(0), .SAT(1)) dut_t (
        .CLK(CLK), .s_RST(s_RST), .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q),
        .conj_b(conj_b), .input_strobe(input_strobe), .ovf_clr(ovf_clr),
        .p_i(pi_t), .p_q(pq_t), .output_strobe(os_t), .ovf(ovf_t));
    cmplx_mult_pipe #(.IN_W(16), .OUT_W(16), .SHIFT(15), .ROUND(1), .SAT(0)) dut_w (
        .CLK(CLK), .s_RST(s_RST), .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q),
        .conj_b(conj_b), .input_strobe(input_strobe), .ovf_clr(ovf_clr),
        .p_i(pi_w), .p_q(pq_w), .output_strobe(os_w), .ovf(ovf_w));
    cmplx_mult_pipe #(.IN_W(16), .OUT_W(16), .SHIFT(15), .ROUND(0), .SAT(0)) dut_tw (
        .CLK(CLK), .s_RST(s_RST), .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q),
        .conj_b(conj_b), .input_strobe(input_strobe), .ovf_clr(ovf_clr),
        .p_i(pi_tw), .p_q(pq_tw), .output_strobe(os_tw), .ovf(ovf_tw));
    cmplx_mult_pipe #(.IN_W(16), .OUT_W(34), .SHIFT(0), .ROUND(0), .SAT(1)) dut_x (
        .CLK(CLK), .s_RST(s_RST), .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q),
        .conj_b(conj_b), .input_strobe(input_strobe), .ovf_clr(ovf_clr),
        .p_i(pi_x), .p_q(pq_x), .output_strobe(os_x), .ovf(ovf_x));

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int ai, input int aq, input int bi, input int bq, input int cj);
        a_i = 16'(ai);
        a_q = 16'(aq);
        b_i = 16'(bi);
        b_q = 16'(bq);
        conj_b = (cj != 0);
        input_strobe = 1'b1;
    endtask

    task automatic idle();
        input_strobe = 1'b0;
    endtask

    // Independent model for the default build: round half up, >>15, clamp to Q15.
    function automatic longint scale_def(input longint x);
        longint r;
        r = (x + 64'sd16384) >>> 15;
        if (r > 64'sd32767) r = 64'sd32767;
        else if (r < -64'sd32768) r = -64'sd32768;
        return r;
    endfunction

    longint q_ei[$], q_eq[$];
    longint e_i, e_q, bq_e;
    int r_ai, r_aq, r_bi, r_bq, r_cj;
    logic r_stb;
    logic [3:0] hist;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_RST = 1'b1; ovf_clr = 1'b0; conj_b = 1'b0; input_strobe = 1'b0;
        a_i = '0; a_q = '0; b_i = '0; b_q = '0;
        tick(); tick();
        check("rst_os", os_d, 0);   check("rst_pi", pi_d, 0);
        check("rst_pq", pq_d, 0);   check("rst_ovf", ovf_d, 0);
        check("rst_os_x", os_x, 0); check("rst_pi_x", pi_x, 0);
        s_RST = 1'b0;

        // 1. exact math, plain and conjugate, back to back
        drive(3, 4, 5, -6, 0); tick();
        drive(3, 4, 5, -6, 1); tick();
        idle(); tick();
        check("t1_lat_os", os_x, 0);
        tick();
        check("t1_os0", os_x, 1); check("t1_pi0", pi_x, 39); check("t1_pq0", pq_x, 2);
        tick();
        check("t1_os1", os_x, 1); check("t1_pi1", pi_x, -9); check("t1_pq1", pq_x, 38);
        tick();
        check("t1_os_off", os_x, 0); check("t1_hold_pi", pi_x, -9); check("t1_hold_pq", pq_x, 38);

        // 2. all most-negative inputs: I=0, Q=2^31
        drive(-32768, -32768, -32768, -32768, 0); tick();
        idle(); tick(); tick();
        check("t2_ovf_early", ovf_d, 0);
        tick();
        check("t2_pi_d", pi_d, 0);    check("t2_pq_d", pq_d, 32767);   check("t2_ovf_d", ovf_d, 1);
        check("t2_pq_t", pq_t, 32767); check("t2_ovf_t", ovf_t, 1);
        check("t2_pq_w", pq_w, 0);    check("t2_ovf_w", ovf_w, 1);
        check("t2_pq_tw", pq_tw, 0);  check("t2_ovf_tw", ovf_tw, 1);
        check("t2_pi_x", pi_x, 0);    check("t2_pq_x", pq_x, 64'sd2147483648);
        check("t2_ovf_x", ovf_x, 0);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("t2_clr", ovf_d, 0); check("t2_clr_hold", pq_d, 32767);

        // 3. rounding at exactly half an LSB
        drive(1, 0, 16384, 0, 0); tick();
        idle(); tick(); tick(); tick();
        check("t3_pi_d", pi_d, 1);  check("t3_pq_d", pq_d, 0);
        check("t3_pi_t", pi_t, 0);  check("t3_pi_w", pi_w, 1);
        check("t3_pi_tw", pi_tw, 0); check("t3_pi_x", pi_x, 16384);
        check("t3_ovf_d", ovf_d, 0);

        // 4. strobe pattern 1,1,0,1
        drive(3, 4, 5, -6, 0); tick();
        drive(-7, 2, 10, 3, 1); tick();
        drive(100, 100, 100, 100, 0); idle(); tick();
        check("t4_lat", os_x, 0);
        drive(1000, -2000, -3, 5, 0); tick();
        idle();
        check("t4_os0", os_x, 1); check("t4_pi0", pi_x, 39); check("t4_pq0", pq_x, 2);
        tick();
        check("t4_os1", os_d, 1); check("t4_pi1", pi_x, -64); check("t4_pq1", pq_x, 41);
        tick();
        check("t4_gap", os_x, 0); check("t4_gap_hold", pi_x, -64);
        tick();
        check("t4_os3", os_x, 1); check("t4_pi3", pi_x, 7000); check("t4_pq3", pq_x, 11000);
        tick();
        check("t4_end", os_x, 0);

        // 5. reset with two samples in flight
        drive(-32768, -32768, -32768, -32768, 0); tick();
        tick();
        idle(); s_RST = 1'b1; tick(); s_RST = 1'b0;
        check("t5_pi", pi_d, 0); check("t5_pq", pq_d, 0);
        check("t5_os", os_d, 0); check("t5_ovf", ovf_d, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_no_os", os_d, 0); check("t5_no_ovf", ovf_d, 0);
        end
        drive(1, 0, 16384, 0, 0); tick();
        idle(); tick(); tick();
        check("t5_new_lat", os_d, 0);
        tick();
        check("t5_new_os", os_d, 1); check("t5_new_pi", pi_d, 1);

        // 6. ovf_clr in the same cycle as a saturating result
        drive(-32768, -32768, -32768, -32768, 0); tick();
        idle(); tick(); tick();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("t6_os", os_d, 1); check("t6_set_wins", ovf_d, 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("t6_clr", ovf_d, 0);

        // random samples against a direct four-multiplier model
        hist = 4'b0000;
        for (int i = 0; i < 404; i++) begin
            r_stb = (i < 400) && ($urandom_range(0, 3) != 0);
            r_ai = int'($urandom_range(0, 65535)) - 32768;
            r_aq = int'($urandom_range(0, 65535)) - 32768;
            r_bi = int'($urandom_range(0, 65535)) - 32768;
            r_bq = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 15) == 0) r_bq = -32768;
            r_cj = int'($urandom_range(0, 1));
            drive(r_ai, r_aq, r_bi, r_bq, r_cj);
            input_strobe = r_stb;
            if (r_stb) begin
                bq_e = (r_cj != 0) ? -longint'(r_bq) : longint'(r_bq);
                e_i = longint'(r_ai) * longint'(r_bi) - longint'(r_aq) * bq_e;
                e_q = longint'(r_ai) * bq_e + longint'(r_aq) * longint'(r_bi);
                q_ei.push_back(e_i);
                q_eq.push_back(e_q);
            end
            tick();
            hist = {hist[2:0], r_stb};
            check("rnd_os", os_d, hist[3]);
            if (os_x && q_ei.size() > 0) begin
                e_i = q_ei.pop_front();
                e_q = q_eq.pop_front();
                check("rnd_pi_x", pi_x, e_i); check("rnd_pq_x", pq_x, e_q);
                check("rnd_pi_d", pi_d, scale_def(e_i)); check("rnd_pq_d", pq_d, scale_def(e_q));
            end
        end
        idle();
        check("rnd_drained", q_ei.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
